// File: rtl/floo_vc_credit_assignment.sv
// Per-output VC allocator: picks a permitted, credited, unlocked downstream VC
// round-robin, tracks downstream credits and holds wormhole locks per packet.
module floo_vc_credit_assignment #(
    parameter int NumVC       = 4,
    parameter int NumVCWidth  = NumVC > 1 ? $clog2(NumVC) : 1,
    parameter int NumInputs   = 5,
    parameter int NumInWidth  = NumInputs > 1 ? $clog2(NumInputs) : 1,
    parameter int NumDirs     = 5,
    parameter int DirWidth    = 3,
    parameter int VCDepth     = 3,
    parameter int CreditWidth = $clog2(VCDepth + 1),
    parameter logic [NumDirs-1:0][NumVC-1:0] DirVcMask = '1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          sa_global_v_i,
    input  logic [NumInputs-1:0]          sa_global_input_dir_oh_i,
    input  logic [NumInputs*DirWidth-1:0] look_ahead_routing_i,
    input  logic [NumInputs-1:0]          head_i,
    input  logic [NumInputs-1:0]          tail_i,
    input  logic                          credit_v_i,
    input  logic [NumVCWidth-1:0]         credit_id_i,
    output logic                          vc_assignment_v_o,
    output logic [NumVCWidth-1:0]         vc_assignment_id_o,
    output logic [DirWidth-1:0]           look_ahead_routing_sel_o,
    output logic [NumVC-1:0]              vc_avail_o,
    output logic                          credit_err_o
);

    logic [NumInputs-1:0][DirWidth-1:0] la_dir;
    logic [CreditWidth-1:0]             credit_q [NumVC];
    logic [NumVC-1:0]                   locked_q;
    logic [NumInWidth-1:0]              owner_q  [NumVC];
    logic [NumVCWidth-1:0]              rr_q;

    logic                  sel_any;
    logic [NumInWidth-1:0] src;
    logic [DirWidth-1:0]   dir;
    logic [NumVC-1:0]      dir_mask;
    logic [NumVC-1:0]      cand;
    logic [NumVC-1:0]      owned;
    logic                  head_sel;
    logic                  go;
    logic                  lock_hit;
    logic                  set_lock;
    logic                  clr_lock;
    logic                  no_lock_err;
    logic [NumVCWidth-1:0] win;
    logic [NumVC-1:0]      credit_inc;
    logic [NumVC-1:0]      credit_dec;
    logic                  credit_ovf;

    assign la_dir  = look_ahead_routing_i;
    assign sel_any = sa_global_v_i && (|sa_global_input_dir_oh_i);

    // OR-reduce the one-hot select into an index
    always_comb begin
        src = '0;
        for (int i = 0; i < NumInputs; i++) begin
            if (sa_global_input_dir_oh_i[i]) src = src | NumInWidth'(i);
        end
    end

    assign dir      = la_dir[src];
    assign head_sel = head_i[src];

    always_comb begin
        dir_mask = '0;
        for (int d = 0; d < NumDirs; d++) begin
            if (dir == DirWidth'(d)) dir_mask = DirVcMask[d];
        end
    end

    always_comb begin
        vc_avail_o = '0;
        owned      = '0;
        for (int v = 0; v < NumVC; v++) begin
            vc_avail_o[v] = (credit_q[v] != '0) && !locked_q[v];
            owned[v]      = locked_q[v] && (owner_q[v] == src);
        end
    end

    assign cand = dir_mask & vc_avail_o;

    always_comb begin
        go          = 1'b0;
        lock_hit    = 1'b0;
        set_lock    = 1'b0;
        clr_lock    = 1'b0;
        no_lock_err = 1'b0;
        win         = '0;
        if (sel_any) begin
            if (head_sel) begin
                for (int k = 0; k < NumVC; k++) begin
                    if (!go && cand[(int'(rr_q) + k) % NumVC]) begin
                        go  = 1'b1;
                        win = NumVCWidth'((int'(rr_q) + k) % NumVC);
                    end
                end
                set_lock = go && !tail_i[src];
            end else begin
                for (int v = 0; v < NumVC; v++) begin
                    if (owned[v]) begin
                        lock_hit = 1'b1;
                        win      = NumVCWidth'(v);
                    end
                end
                if (!lock_hit) begin
                    no_lock_err = 1'b1;
                end else if (credit_q[win] != '0) begin
                    go       = 1'b1;
                    clr_lock = tail_i[src];
                end
            end
        end
    end

    // A return into a full counter with no same-cycle consumption is an overflow
    always_comb begin
        credit_inc = '0;
        credit_dec = '0;
        credit_ovf = 1'b0;
        for (int v = 0; v < NumVC; v++) begin
            credit_inc[v] = credit_v_i && (credit_id_i == NumVCWidth'(v));
            credit_dec[v] = go && (win == NumVCWidth'(v));
            if (credit_inc[v] && !credit_dec[v] && credit_q[v] == CreditWidth'(VCDepth))
                credit_ovf = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int v = 0; v < NumVC; v++) begin
                credit_q[v] <= CreditWidth'(VCDepth);
                owner_q[v]  <= '0;
            end
            locked_q                 <= '0;
            rr_q                     <= '0;
            vc_assignment_v_o        <= 1'b0;
            vc_assignment_id_o       <= '0;
            look_ahead_routing_sel_o <= '0;
            credit_err_o             <= 1'b0;
        end else begin
            for (int v = 0; v < NumVC; v++) begin
                if (credit_inc[v] && !credit_dec[v] && credit_q[v] != CreditWidth'(VCDepth))
                    credit_q[v] <= credit_q[v] + 1'b1;
                else if (credit_dec[v] && !credit_inc[v])
                    credit_q[v] <= credit_q[v] - 1'b1;
            end
            if (set_lock) begin
                locked_q[win] <= 1'b1;
                owner_q[win]  <= src;
            end
            if (clr_lock) locked_q[win] <= 1'b0;
            if (go && head_sel) rr_q <= NumVCWidth'((int'(win) + 1) % NumVC);
            vc_assignment_v_o <= go;
            if (go) begin
                vc_assignment_id_o       <= win;
                look_ahead_routing_sel_o <= dir;
            end
            if (credit_ovf || no_lock_err) credit_err_o <= 1'b1;
        end
    end

    onehot_sel_a: assert property (@(posedge clk_i) disable iff (rst_i)
        sa_global_v_i |-> $onehot0(sa_global_input_dir_oh_i));

endmodule

// File: tb/tb_floo_vc_credit_assignment.sv
// Bench for floo_vc_credit_assignment: directed scenarios and random traffic
// checked against a behavioural allocator model.
module tb_floo_vc_credit_assignment;

    localparam int NV    = 4;
    localparam int NVW   = 2;
    localparam int NI    = 5;
    localparam int DW    = 3;
    localparam int ND    = 5;
    localparam int DEPTH = 3;
    // direction 4 may only use VC0; all other directions may use any VC
    localparam logic [ND-1:0][NV-1:0] MASK = {4'b0001, 4'b1111, 4'b1111, 4'b1111, 4'b1111};

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 sa_v = 1'b0;
    logic [NI-1:0]        oh = '0;
    logic [NI-1:0][DW-1:0] la = '0;
    logic [NI-1:0]        head = '0;
    logic [NI-1:0]        tail = '0;
    logic                 crv = 1'b0;
    logic [NVW-1:0]       crid = '0;
    logic                 vo;
    logic [NVW-1:0]       id;
    logic [DW-1:0]        sel;
    logic [NV-1:0]        avail;
    logic                 err;

    int vecs = 0;
    int errs = 0;

    int m_cred [NV];
    bit m_lock [NV];
    int m_own  [NV];
    int m_rr;
    bit m_err;
    bit e_v;
    int e_id;
    int e_sel;

    always #5 clk = ~clk;

    floo_vc_credit_assignment #(
        .NumVC(NV), .NumInputs(NI), .NumDirs(ND), .DirWidth(DW),
        .VCDepth(DEPTH), .DirVcMask(MASK)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .sa_global_v_i(sa_v),
        .sa_global_input_dir_oh_i(oh),
        .look_ahead_routing_i(la),
        .head_i(head),
        .tail_i(tail),
        .credit_v_i(crv),
        .credit_id_i(crid),
        .vc_assignment_v_o(vo),
        .vc_assignment_id_o(id),
        .look_ahead_routing_sel_o(sel),
        .vc_avail_o(avail),
        .credit_err_o(err)
    );

    function automatic logic [NV-1:0] m_avail();
        logic [NV-1:0] r;
        for (int v = 0; v < NV; v++) r[v] = (m_cred[v] > 0) && !m_lock[v];
        return r;
    endfunction

    function automatic void model_step(bit v, int src, int dir, bit h, bit t, bit cv, int cid);
        int use_vc;
        int lv;
        int c;
        use_vc = -1;
        if (rst) begin
            for (int k = 0; k < NV; k++) begin
                m_cred[k] = DEPTH;
                m_lock[k] = 0;
                m_own[k]  = 0;
            end
            m_rr = 0; m_err = 0; e_v = 0; e_id = 0; e_sel = 0;
            return;
        end
        if (v && src >= 0) begin
            if (h) begin
                for (int k = 0; k < NV; k++) begin
                    c = (m_rr + k) % NV;
                    if (use_vc < 0 && MASK[dir][c] && m_cred[c] > 0 && !m_lock[c]) use_vc = c;
                end
                if (use_vc >= 0) begin
                    m_rr = (use_vc + 1) % NV;
                    if (!t) begin
                        m_lock[use_vc] = 1;
                        m_own[use_vc]  = src;
                    end
                end
            end else begin
                lv = -1;
                for (int k = 0; k < NV; k++) if (m_lock[k] && m_own[k] == src) lv = k;
                if (lv < 0) m_err = 1;
                else if (m_cred[lv] > 0) begin
                    use_vc = lv;
                    if (t) m_lock[lv] = 0;
                end
            end
        end
        if (cv && cid != use_vc) begin
            if (m_cred[cid] == DEPTH) m_err = 1;
            else m_cred[cid]++;
        end
        if (use_vc >= 0 && !(cv && cid == use_vc)) m_cred[use_vc]--;
        e_v = (use_vc >= 0);
        if (e_v) begin
            e_id  = use_vc;
            e_sel = dir;
        end
    endfunction

    // Applies one cycle of inputs, advances the model, returns 1 ns after the edge
    task automatic drive(input bit v, input int src, input int dir, input bit h, input bit t,
                         input bit cv, input int cid);
        sa_v = v;
        oh   = (src >= 0) ? NI'(1 << src) : '0;
        for (int i = 0; i < NI; i++) begin
            la[i]   = DW'($urandom_range(0, ND - 1));
            head[i] = 1'($urandom);
            tail[i] = 1'($urandom);
        end
        if (src >= 0) begin
            la[src]   = DW'(dir);
            head[src] = h;
            tail[src] = t;
        end
        crv  = cv;
        crid = NVW'(cid);
        model_step(v, src, dir, h, t, cv, cid);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, -1, 0, 0, 0, 0, 0);
        drive(0, -1, 0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vecs++;
        if (vo !== 1'b0 || id !== '0 || sel !== '0 || err !== 1'b0 || avail !== 4'b1111) begin
            errs++;
            $display("FAIL reset: got v=%0b id=%0d sel=%0d err=%0b avail=%b, want 0 0 0 0 1111",
                     vo, id, sel, err, avail);
        end
        for (int v = 0; v < NV; v++) begin
            vecs++;
            if (dut.credit_q[v] !== 2'(DEPTH)) begin
                errs++;
                $display("FAIL reset_credit%0d: got %0d want %0d", v, dut.credit_q[v], DEPTH);
            end
        end
    endtask

    task automatic test_single_flit();
        do_reset();
        drive(1, 2, 1, 1, 1, 0, 0);
        vecs++;
        if (vo !== 1'b1 || id !== 2'd0 || sel !== 3'd1) begin
            errs++;
            $display("FAIL single_flit: got v=%0b id=%0d sel=%0d, want 1 0 1", vo, id, sel);
        end
        vecs++;
        if (dut.credit_q[0] !== 2'd2 || dut.locked_q !== 4'b0000 || avail !== m_avail()) begin
            errs++;
            $display("FAIL single_flit_state: got cred0=%0d lock=%b avail=%b, want 2 0000 %b",
                     dut.credit_q[0], dut.locked_q, avail, m_avail());
        end
    endtask

    task automatic test_wormhole();
        do_reset();
        drive(1, 4, 0, 1, 1, 0, 0);
        drive(1, 0, 2, 1, 0, 0, 0);
        vecs++;
        if (vo !== 1'b1 || id !== 2'd1 || sel !== 3'd2) begin
            errs++;
            $display("FAIL worm_head: got v=%0b id=%0d sel=%0d, want 1 1 2", vo, id, sel);
        end
        drive(1, 3, 0, 1, 1, 0, 0);
        vecs++;
        if (vo !== 1'b1 || id === 2'd1 || id !== NVW'(e_id)) begin
            errs++;
            $display("FAIL worm_skip: got v=%0b id=%0d, want 1 %0d (not the locked VC1)", vo, id, e_id);
        end
        drive(1, 0, 2, 0, 0, 0, 0);
        vecs++;
        if (vo !== 1'b1 || id !== 2'd1) begin
            errs++;
            $display("FAIL worm_body: got v=%0b id=%0d, want 1 1", vo, id);
        end
        drive(1, 0, 2, 0, 1, 0, 0);
        vecs++;
        if (vo !== 1'b1 || id !== 2'd1 || dut.credit_q[1] !== 2'd0 || dut.locked_q[1] !== 1'b0) begin
            errs++;
            $display("FAIL worm_tail: got v=%0b id=%0d cred1=%0d lock1=%0b, want 1 1 0 0",
                     vo, id, dut.credit_q[1], dut.locked_q[1]);
        end
        vecs++;
        if (avail !== m_avail()) begin
            errs++;
            $display("FAIL worm_avail: got %b want %b", avail, m_avail());
        end
    endtask

    task automatic test_mask_credit();
        do_reset();
        for (int k = 0; k < 3; k++) drive(1, 1, 4, 1, 1, 0, 0);
        drive(1, 1, 4, 1, 1, 0, 0);
        vecs++;
        if (vo !== 1'b0 || vo !== e_v) begin
            errs++;
            $display("FAIL mask_drained: got v=%0b want 0", vo);
        end
        drive(0, -1, 0, 0, 0, 1, 0);
        drive(1, 1, 4, 1, 1, 0, 0);
        vecs++;
        if (vo !== 1'b1 || id !== 2'd0 || sel !== 3'd4) begin
            errs++;
            $display("FAIL mask_refill: got v=%0b id=%0d sel=%0d, want 1 0 4", vo, id, sel);
        end
    endtask

    task automatic test_credit_return();
        do_reset();
        drive(1, 1, 0, 1, 1, 0, 0);
        drive(1, 1, 0, 1, 1, 0, 0);
        drive(1, 0, 3, 1, 0, 0, 0);
        drive(1, 0, 3, 0, 0, 0, 0);
        drive(1, 0, 3, 0, 1, 1, 2);
        vecs++;
        if (vo !== 1'b1 || id !== 2'd2 || dut.credit_q[2] !== 2'd1 || m_cred[2] != 1) begin
            errs++;
            $display("FAIL same_cycle_return: got v=%0b id=%0d cred2=%0d, want 1 2 1", vo, id, dut.credit_q[2]);
        end
        vecs++;
        if (err !== 1'b0) begin
            errs++;
            $display("FAIL no_false_err: got err=%0b want 0", err);
        end
        drive(0, -1, 0, 0, 0, 1, 3);
        vecs++;
        if (err !== 1'b1 || dut.credit_q[3] !== 2'd3) begin
            errs++;
            $display("FAIL overflow: got err=%0b cred3=%0d, want 1 3", err, dut.credit_q[3]);
        end
        drive(0, -1, 0, 0, 0, 0, 0);
        drive(0, -1, 0, 0, 0, 0, 0);
        vecs++;
        if (err !== 1'b1) begin
            errs++;
            $display("FAIL err_sticky: got err=%0b want 1", err);
        end
    endtask

    task automatic test_rr_wrap();
        int want [5];
        want = '{0, 1, 2, 3, 0};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1, $urandom_range(0, NI - 1), $urandom_range(0, 3), 1, 1, 0, 0);
            vecs++;
            if (vo !== 1'b1 || id !== NVW'(want[k]) || id !== NVW'(e_id)) begin
                errs++;
                $display("FAIL rr_wrap%0d: got v=%0b id=%0d, want 1 %0d", k, vo, id, want[k]);
            end
        end
    endtask

    task automatic test_no_lock_and_zero_select();
        do_reset();
        drive(1, -1, 2, 1, 1, 0, 0);
        vecs++;
        if (vo !== 1'b0 || err !== 1'b0) begin
            errs++;
            $display("FAIL zero_select: got v=%0b err=%0b, want 0 0", vo, err);
        end
        drive(1, 3, 2, 0, 0, 0, 0);
        vecs++;
        if (vo !== 1'b0 || err !== 1'b1) begin
            errs++;
            $display("FAIL body_no_lock: got v=%0b err=%0b, want 0 1", vo, err);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        drive(1, 1, 2, 1, 0, 0, 0);
        drive(1, 1, 2, 0, 0, 0, 0);
        rst = 1'b1;
        drive(1, 1, 2, 0, 0, 1, 3);
        rst = 1'b0;
        vecs++;
        if (vo !== 1'b0 || id !== '0 || sel !== '0 || err !== 1'b0 || avail !== 4'b1111 ||
            dut.credit_q[0] !== 2'd3) begin
            errs++;
            $display("FAIL mid_reset: got v=%0b id=%0d sel=%0d err=%0b avail=%b cred0=%0d, want 0 0 0 0 1111 3",
                     vo, id, sel, err, avail, dut.credit_q[0]);
        end
        drive(1, 1, 2, 0, 0, 0, 0);
        vecs++;
        if (vo !== 1'b0 || err !== 1'b1) begin
            errs++;
            $display("FAIL lock_cleared: got v=%0b err=%0b, want 0 1", vo, err);
        end
    endtask

    task automatic test_random();
        int src;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 79) == 0);
            src = ($urandom_range(0, 15) == 0) ? -1 : $urandom_range(0, NI - 1);
            drive($urandom_range(0, 3) != 0, src, $urandom_range(0, ND - 1),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, NV - 1));
            rst = 1'b0;
            vecs++;
            if (vo !== e_v || id !== NVW'(e_id) || sel !== DW'(e_sel) || avail !== m_avail() || err !== m_err) begin
                errs++;
                $display("FAIL random%0d: got v=%0b id=%0d sel=%0d avail=%b err=%0b, want %0b %0d %0d %b %0b",
                         n, vo, id, sel, avail, err, e_v, e_id, e_sel, m_avail(), m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_flit();
        test_wormhole();
        test_mask_credit();
        test_credit_return();
        test_rr_wrap();
        test_no_lock_and_zero_select();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
